cordic_alu_sequencer: RTL and testbench
=======================================

# cordic_alu_sequencer

Iterative CORDIC rotation-mode controller that time-multiplexes the shared 32-bit ALU. It sequences each CORDIC micro-rotation as five ALU operations (two arithmetic right shifts, three add/subtract updates) and holds the X/Y/Z working registers. It fetches the arctangent constant for each iteration from an external table and returns the final vector through a valid/ready handshake. It sits between the processor command path and the ALU, and owns the ALU ports whenever it is busy.

## Interface
- ITER, 16: number of CORDIC iterations; legal range 1..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin; accepted only when ready=1.
- ready  out  1  high only in IDLE.
- x0, y0, z0  in  32 each  signed two's-complement operands, sampled on the accept edge.
- atan_idx  out  5  current iteration index i, registered.
- atan_val  in  32  arctangent constant for atan_idx; external async table; must be stable in UPZ.
- alu_a, alu_b  out  32 each  ALU operands.
- alu_ctrl  out  4  ALU opcode: 0000 add, 0001 subtract (a-b), 1000 arithmetic right shift of a by b[4:0].
- alu_result  in  64  ALU result; only [31:0] used; ALU flags ignored.
- x_out, y_out, z_out  out  32 each  final vector, valid while out_valid=1.
- out_valid  out  1  result-available flag.
- out_ready  in  1  consumer accept.

## Operation
- States: IDLE, SHY, SHX, UPX, UPY, UPZ, DONE.
- **IDLE**
  - ready=1.
  - On start: load x←x0, y←y0, z←z0, i←0; go to SHY.
- **SHY**
  - alu_a=y, alu_b={27'b0,i}, alu_ctrl=1000; ty←alu_result[31:0].
  - Latch direction d←~z[31] (d=1 means z≥0).
- **SHX**
  - alu_a=x, alu_b={27'b0,i}, alu_ctrl=1000; tx←result.
- **UPX**
  - alu_a=x, alu_b=ty, alu_ctrl = d ? 0001 : 0000; x←result.
- **UPY**
  - alu_a=y, alu_b=tx, alu_ctrl = d ? 0000 : 0001; y←result.
- **UPZ**
  - alu_a=z, alu_b=atan_val, alu_ctrl = d ? 0001 : 0000; z←result.
  - If i==ITER-1, go to DONE; else i←i+1 and go to SHY.
- **DONE**
  - out_valid=1; x_out/y_out/z_out hold x/y/z.
  - On out_ready=1, go to IDLE.
- In IDLE and DONE: alu_a=0, alu_b=0, alu_ctrl=0000.
- ALU drives are combinational from state and registers.
- Arithmetic wraps modulo 2^32; no saturation; carry and overflow discarded.
- Direction is fixed per iteration by the sign of z at SHY. The UPZ write of the same iteration does not change it.
- start while not in IDLE is ignored; inputs x0/y0/z0 are not re-sampled.
- No CORDIC gain compensation; the caller pre-scales.

## Timing
- Accept edge = cycle 0 (start & ready).
- Iteration k occupies cycles 5k+1 .. 5k+5, in the order SHY, SHX, UPX, UPY, UPZ.
- out_valid rises at cycle 5·ITER+1 (cycle 81 for ITER=16).
- Handshake completes on the first edge with out_valid & out_ready; ready=1 on the next cycle.
- The minimum accept-to-accept interval is 5·ITER+2 cycles.
- Outputs and out_valid hold indefinitely while out_ready=0.
- atan_idx changes only at the UPZ→SHY edge. It is constant for a full iteration.
- Reset, asynchronous and at any time, including mid-iteration:
  - state=IDLE, ready=1, out_valid=0, i=0.
  - x, y, z, tx, ty, x_out/y_out/z_out=0.
  - alu_a=alu_b=0, alu_ctrl=0000.
  - The in-flight operation is discarded.

## Test plan
- **Reset:** assert rst_n=0 mid-stream.
  - Immediately: ready=1, out_valid=0, all data outputs 0, alu_ctrl=0000.
  - After release: IDLE held until start.
- **ITER=1, z≥0:** x0=100, y0=0, z0=5, atan_val=3.
  - alu_ctrl sequence 1000, 1000, 0001, 0000, 0001.
  - out_valid at cycle 6 with x=100, y=100, z=2.
- **ITER=1, z<0:** x0=100, y0=50, z0=0xFFFFFFFB, atan_val=3.
  - Result x=150, y=0xFFFFFFCE (−50), z=0xFFFFFFFE (−2).
- **ITER=2, shift path:** x0=64, y0=32, z0=10, atan[0]=4, atan[1]=2.
  - After iteration 0: x=32, y=96, z=6.
  - Final: x=0xFFFFFFF0 (−16), y=112, z=4.
  - atan_idx=1 during cycles 6–10; out_valid at cycle 11.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and start pulses are ignored.
  - out_ready=1 completes the handshake; ready=1 on the next cycle.
  - A back-to-back start is accepted and the new result is correct.
- **Wrap:** ITER=1, x0=0x7FFFFFFF, y0=1, z0=0xFFFFFFFF, atan_val=0.
  - Result x=0x80000000, y=0x80000002, z=0xFFFFFFFF.
  - No flag or exception.

Source files
------------

// File: rtl/cordic_alu_sequencer.sv
// cordic_alu_sequencer
// Rotation-mode CORDIC controller that borrows the shared 32-bit ALU.
// Each micro-rotation takes five ALU operations in this order: shift y, shift x,
// update x, update y, update z. The block holds the X/Y/Z working registers and
// returns the final vector through a valid/ready handshake.
module cordic_alu_sequencer #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] z0,
    output logic [4:0]  atan_idx,
    input  logic [31:0] atan_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SHY  = 3'd1,
        S_SHX  = 3'd2,
        S_UPX  = 3'd3,
        S_UPY  = 3'd4,
        S_UPZ  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  i_r;
    logic [31:0] x_r;
    logic [31:0] y_r;
    logic [31:0] z_r;
    logic [31:0] tx_r;
    logic [31:0] ty_r;
    logic        d_r;
    logic        ready_r;
    logic        out_valid_r;

    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [3:0]  alu_ctrl_s;
    logic [31:0] res_s;
    logic        alu_hi_unused_s;

    // Only the low word of the ALU result carries data; flags and high word are ignored.
    assign res_s           = alu_result[31:0];
    assign alu_hi_unused_s = ^alu_result[63:32];

    // Next state and ALU operand/opcode selection for the current micro-operation.
    always_comb begin
        state_s    = state_r;
        alu_a_s    = 32'd0;
        alu_b_s    = 32'd0;
        alu_ctrl_s = OP_ADD;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_SHY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHY: begin
                alu_a_s    = y_r;
                alu_b_s    = {27'd0, i_r};
                alu_ctrl_s = OP_SRA;
                state_s    = S_SHX;
            end
            S_SHX: begin
                alu_a_s    = x_r;
                alu_b_s    = {27'd0, i_r};
                alu_ctrl_s = OP_SRA;
                state_s    = S_UPX;
            end
            S_UPX: begin
                alu_a_s    = x_r;
                alu_b_s    = ty_r;
                alu_ctrl_s = d_r ? OP_SUB : OP_ADD;
                state_s    = S_UPY;
            end
            S_UPY: begin
                alu_a_s    = y_r;
                alu_b_s    = tx_r;
                alu_ctrl_s = d_r ? OP_ADD : OP_SUB;
                state_s    = S_UPZ;
            end
            S_UPZ: begin
                alu_a_s    = z_r;
                alu_b_s    = atan_val;
                alu_ctrl_s = d_r ? OP_SUB : OP_ADD;
                if (i_r == LAST_IDX) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_SHY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, working registers and handshake flags; reset discards any in-flight rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            i_r         <= 5'd0;
            x_r         <= 32'd0;
            y_r         <= 32'd0;
            z_r         <= 32'd0;
            tx_r        <= 32'd0;
            ty_r        <= 32'd0;
            d_r         <= 1'b0;
            ready_r     <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == S_IDLE);
            out_valid_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        x_r <= x0;
                        y_r <= y0;
                        z_r <= z0;
                        i_r <= 5'd0;
                    end
                end
                S_SHY: begin
                    ty_r <= res_s;
                    // Direction is frozen here so the later z update cannot flip it.
                    d_r  <= ~z_r[31];
                end
                S_SHX: begin
                    tx_r <= res_s;
                end
                S_UPX: begin
                    x_r <= res_s;
                end
                S_UPY: begin
                    y_r <= res_s;
                end
                S_UPZ: begin
                    z_r <= res_s;
                    if (i_r != LAST_IDX) begin
                        i_r <= i_r + 5'd1;
                    end
                end
                default: begin
                    i_r <= i_r;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign out_valid = out_valid_r;
    assign atan_idx  = i_r;
    assign x_out     = x_r;
    assign y_out     = y_r;
    assign z_out     = z_r;
    assign alu_a     = alu_a_s;
    assign alu_b     = alu_b_s;
    assign alu_ctrl  = alu_ctrl_s;

endmodule

// File: tb/tb_cordic_alu_sequencer.sv
// Scoreboard bench for cordic_alu_sequencer: one instance with ITER=1 and one
// with ITER=2, each driven by a behavioural ALU. Expected vectors are pushed at
// accept time and checked by a monitor when the result is handed over.
module tb_cordic_alu_sequencer;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start1, ready1, out_valid1, out_ready1;
    logic [31:0] x01, y01, z01, atan_val1, alu_a1, alu_b1, x_out1, y_out1, z_out1;
    logic [4:0]  atan_idx1;
    logic [3:0]  alu_ctrl1;
    logic [63:0] alu_result1;

    logic        start2, ready2, out_valid2, out_ready2;
    logic [31:0] x02, y02, z02, atan_val2, alu_a2, alu_b2, x_out2, y_out2, z_out2;
    logic [4:0]  atan_idx2;
    logic [3:0]  alu_ctrl2;
    logic [63:0] alu_result2;

    int n_vec = 0;
    int n_err = 0;
    res_t q1[$];
    res_t q2[$];

    logic [3:0] seq_pos [5] = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0001};
    logic [3:0] seq_neg [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    // Shared ALU behaviour; high word filled with junk that the DUT must ignore.
    function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b1000: r = $signed(a) >>> b[4:0];
            default: r = 32'hDEADBEEF;
        endcase
        return {32'h5A5A5A5A, r};
    endfunction

    assign alu_result1 = alu_model(alu_a1, alu_b1, alu_ctrl1);
    assign alu_result2 = alu_model(alu_a2, alu_b2, alu_ctrl2);
    assign atan_val2   = (atan_idx2 == 5'd0) ? 32'd4 : 32'd2;

    cordic_alu_sequencer #(.ITER(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1),
        .x0(x01), .y0(y01), .z0(z01), .atan_idx(atan_idx1), .atan_val(atan_val1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1), .alu_result(alu_result1),
        .x_out(x_out1), .y_out(y_out1), .z_out(z_out1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    cordic_alu_sequencer #(.ITER(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ready(ready2),
        .x0(x02), .y0(y02), .z0(z02), .atan_idx(atan_idx2), .atan_val(atan_val2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2), .alu_result(alu_result2),
        .x_out(x_out2), .y_out(y_out2), .z_out(z_out2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Wait for ready, present one vector for a single cycle; returns just after the accept edge.
    task automatic accept1(input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] za,
                           input logic [31:0] at, input logic push,
                           input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez);
        int w;
        w = 0;
        @(posedge clk); #1;
        while (!ready1 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready1) fail_now("accept1_wait");
        x01 = xa; y01 = ya; z01 = za; atan_val1 = at; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        if (push) q1.push_back('{ex, ey, ez});
    endtask

    task automatic accept2(input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] za,
                           input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez);
        int w;
        w = 0;
        @(posedge clk); #1;
        while (!ready2 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready2) fail_now("accept2_wait");
        x02 = xa; y02 = ya; z02 = za; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        q2.push_back('{ex, ey, ez});
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((q1.size() != 0 || q2.size() != 0) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (q1.size() != 0 || q2.size() != 0) fail_now("drain");
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; out_ready1 = 1'b1; x01 = 32'd0; y01 = 32'd0; z01 = 32'd0; atan_val1 = 32'd0;
        start2 = 1'b0; out_ready2 = 1'b1; x02 = 32'd0; y02 = 32'd0; z02 = 32'd0;

        // Monitor: compare whenever a result is handed over on the coming edge.
        fork
            forever begin
                res_t e1;
                res_t e2;
                @(negedge clk);
                if (rst_n && out_valid1 && out_ready1) begin
                    if (q1.size() == 0) begin
                        fail_now("mon1_unexpected");
                    end else begin
                        e1 = q1.pop_front();
                        chk("mon1_x", x_out1, e1.x);
                        chk("mon1_y", y_out1, e1.y);
                        chk("mon1_z", z_out1, e1.z);
                    end
                end
                if (rst_n && out_valid2 && out_ready2) begin
                    if (q2.size() == 0) begin
                        fail_now("mon2_unexpected");
                    end else begin
                        e2 = q2.pop_front();
                        chk("mon2_x", x_out2, e2.x);
                        chk("mon2_y", y_out2, e2.y);
                        chk("mon2_z", z_out2, e2.z);
                    end
                end
            end
        join_none

        // Reset state.
        #12;
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_valid", 32'(out_valid1), 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl1), 32'd0);
        chk("rst_xout", x_out1, 32'd0);
        chk("rst_ready2", 32'(ready2), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(ready1), 32'd1);

        // ITER=1, z >= 0: opcode sequence and out_valid at cycle 6.
        accept1(32'd100, 32'd0, 32'd5, 32'd3, 1'b1, 32'd100, 32'd100, 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("v1_ctrl", 32'(alu_ctrl1), 32'(seq_pos[k]));
        end
        chk("v1_valid_c5", 32'(out_valid1), 32'd0);
        @(negedge clk);
        chk("v1_valid_c6", 32'(out_valid1), 32'd1);
        wait_drain();

        // ITER=1, z < 0.
        accept1(32'd100, 32'd50, 32'hFFFFFFFB, 32'd3, 1'b1, 32'd150, 32'hFFFFFFCE, 32'hFFFFFFFE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("v2_ctrl", 32'(alu_ctrl1), 32'(seq_neg[k]));
        end
        wait_drain();

        // Wrap-around.
        accept1(32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h80000000, 32'h80000002, 32'hFFFFFFFF);
        wait_drain();

        // ITER=2 shift path on the second instance.
        accept2(32'd64, 32'd32, 32'd10, 32'hFFFFFFF0, 32'd112, 32'd4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("it2_idx", 32'(atan_idx2), (k < 5) ? 32'd0 : 32'd1);
            if (k == 5) chk("it2_y_after0", alu_a2, 32'd96);
            if (k == 6) chk("it2_x_after0", alu_a2, 32'd32);
            if (k == 7) chk("it2_ty1", alu_b2, 32'd48);
            if (k == 9) chk("it2_z_after0", alu_a2, 32'd6);
            if (k == 9) chk("it2_valid_c10", 32'(out_valid2), 32'd0);
        end
        @(negedge clk);
        chk("it2_valid_c11", 32'(out_valid2), 32'd1);
        wait_drain();

        // Backpressure: hold out_ready low, poke start, then release with a back-to-back start.
        out_ready1 = 1'b0;
        accept1(32'd100, 32'd0, 32'd5, 32'd3, 1'b1, 32'd100, 32'd100, 32'd2);
        repeat (6) @(negedge clk);
        chk("bp_valid", 32'(out_valid1), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start1 = k[0];
            x01 = 32'd999;
            @(negedge clk);
            chk("bp_x_hold", x_out1, 32'd100);
            chk("bp_y_hold", y_out1, 32'd100);
            chk("bp_z_hold", z_out1, 32'd2);
            chk("bp_valid_hold", 32'(out_valid1), 32'd1);
            chk("bp_not_ready", 32'(ready1), 32'd0);
        end
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        start1 = 1'b1; x01 = 32'd200; y01 = 32'd10; z01 = 32'd0; atan_val1 = 32'd3;
        q1.push_back('{32'd190, 32'd210, 32'hFFFFFFFD});
        @(posedge clk); #1;
        chk("hs_ready", 32'(ready1), 32'd1);
        chk("hs_valid_low", 32'(out_valid1), 32'd0);
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("b2b_accepted", 32'(ready1), 32'd0);
        wait_drain();

        // Asynchronous reset in the middle of an iteration.
        accept1(32'd100, 32'd0, 32'd5, 32'd3, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(ready1), 32'd1);
        chk("mrst_valid", 32'(out_valid1), 32'd0);
        chk("mrst_xout", x_out1, 32'd0);
        chk("mrst_yout", y_out1, 32'd0);
        chk("mrst_alu_a", alu_a1, 32'd0);
        chk("mrst_alu_b", alu_b1, 32'd0);
        chk("mrst_ctrl", 32'(alu_ctrl1), 32'd0);
        chk("mrst_idx2", 32'(atan_idx2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_idle", 32'(ready1), 32'd1);
        chk("mrst_no_valid", 32'(out_valid1), 32'd0);

        // Recovery after reset.
        accept1(32'd100, 32'd50, 32'hFFFFFFFB, 32'd3, 1'b1, 32'd150, 32'hFFFFFFCE, 32'hFFFFFFFE);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
